// File: rtl/btn_pkg.sv
// Shared constants, channel state type and counter sizing for the button conditioner.
package btn_pkg;

    localparam int unsigned NUM_BTN             = 4;
    localparam int unsigned CLK_HZ              = 125_000_000;
    localparam int unsigned DEBOUNCE_MS         = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic {
        ST_STABLE    = 1'b0,
        ST_CANDIDATE = 1'b1
    } ch_state_e;

    // Bits needed to hold a count of 0..n inclusive, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) <= 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter, debounced level and press strobe.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_raw,
    output logic level,
    output logic pulse,
    output logic pulse_next_c
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // A level change is accepted only after the synchronized input disagrees for a full count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;

        unique case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync2_q != level_q) begin
                    state_d = ST_CANDIDATE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_CANDIDATE: begin
                if (sync2_q == level_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase

        pulse_d = level_d & ~level_q;
    end

    assign level        = level_q;
    assign pulse        = pulse_q;
    assign pulse_next_c = pulse_d;

endmodule

// File: rtl/btn_conditioner.sv
// Four independent debounced button channels with a combined registered press strobe.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               any_pulse
);

    logic [NUM_BTN-1:0] pulse_next;
    logic               any_pulse_q, any_pulse_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .clr         (clr),
            .btn_raw     (btn_raw[i]),
            .level       (btn_level[i]),
            .pulse       (btn_pulse[i]),
            .pulse_next_c(pulse_next[i])
        );
    end

    // Built from the channels' next-state strobes so it lines up with btn_pulse.
    always_comb begin
        any_pulse_d = |pulse_next;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            any_pulse_q <= 1'b0;
        end else begin
            any_pulse_q <= any_pulse_d;
        end
    end

    assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: a run-length reference model predicts outputs each edge; a monitor compares.
module tb_btn_conditioner;

    localparam int unsigned N = 4;

    logic       clk;
    logic       clr;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic       any_pulse;

    btn_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk      (clk),
        .clr      (clr),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .any_pulse(any_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [8:0] exp_q[$];

    // Reference: raw input reaches the debouncer two edges late; a level flips once the
    // delayed input has disagreed with it on N+1 consecutive edges. Press = 0->1 flip.
    logic [3:0] hist1 = '0, hist2 = '0, seen, m_level = '0, m_pulse = '0;
    int         run [4] = '{default: 0};

    always @(posedge clk) begin
        if (clr) begin
            hist1   = '0;
            hist2   = '0;
            m_level = '0;
            m_pulse = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            seen    = hist2;
            hist2   = hist1;
            hist1   = btn_raw;
            m_pulse = '0;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] != m_level[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == int'(N) + 1) begin
                        m_level[i] = ~m_level[i];
                        m_pulse[i] = m_level[i];
                        run[i]     = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
        exp_q.push_back({m_level, m_pulse, |m_pulse});
    end

    // Monitor: one expected record per edge, compared away from the edge.
    always begin
        logic [8:0] e;
        @(posedge clk);
        #1;
        cycle++;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty cycle %0d: no expected record", cycle);
        end else begin
            e = exp_q.pop_front();
            if ({btn_level, btn_pulse, any_pulse} !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got level=%b pulse=%b any=%b, expected level=%b pulse=%b any=%b",
                         cycle, btn_level, btn_pulse, any_pulse, e[8:5], e[4:1], e[0]);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic c, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            btn_raw = r;
            clr     = c;
        end
    endtask

    initial begin
        clr     = 1'b1;
        btn_raw = '0;
        step(4'b0000, 1'b1, 3);
        step(4'b0000, 1'b0, 5);

        // clean press on bit 2
        step(4'b0100, 1'b0, 20);
        step(4'b0000, 1'b0, 10);

        // bouncing press on bit 3
        step(4'b1000, 1'b0, 1);
        step(4'b0000, 1'b0, 1);
        step(4'b1000, 1'b0, 1);
        step(4'b0000, 1'b0, 1);
        step(4'b1000, 1'b0, 20);
        step(4'b0000, 1'b0, 10);

        // short glitch on bit 1
        step(4'b0010, 1'b0, 3);
        step(4'b0000, 1'b0, 10);

        // simultaneous press on bits 0 and 3
        step(4'b1001, 1'b0, 20);
        step(4'b0000, 1'b0, 10);

        // clear mid-count while bit 2 is held, then release
        step(4'b0100, 1'b0, 4);
        step(4'b0100, 1'b1, 2);
        step(4'b0100, 1'b0, 12);
        step(4'b0000, 1'b0, 12);

        // single-edge-too-short and exactly-long-enough holds
        step(4'b1111, 1'b0, N);
        step(4'b0000, 1'b0, 10);
        step(4'b1111, 1'b0, N + 1);
        step(4'b0000, 1'b0, 12);

        // randomized bouncing, holds and occasional clears
        for (int s = 0; s < 400; s++) begin
            logic [3:0] r;
            logic       c;
            r = 4'($urandom);
            c = ($urandom_range(0, 39) == 0);
            step(r, c, int'($urandom_range(1, 10)));
        end

        step(4'b0000, 1'b0, 12);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1250000 (10 ms at 125 MHz): consecutive stable cycles required to accept a level change; legal range >= 1.
REQ-002 SHALL have port clk, input, 1, the single 125 MHz clock; all logic on its rising edge.
REQ-003 SHALL have port clr, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port btn_raw, input, 4, asynchronous raw bounce-prone buttons; bit 0 = enter, bits 3:1 = sequence buttons.
REQ-005 SHALL have port btn_level, output, 4, registered debounced level per button.
REQ-006 SHALL have port btn_pulse, output, 4, registered one-cycle press strobe per button; bit 0 drives the downstream enter input, bits 3:1 drive BTN[3:1].
REQ-007 SHALL have port any_pulse, output, 1, registered OR of all btn_pulse bits.

Function
REQ-008 Each bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-009 Each channel SHALL hold a stable-state register (btn_level bit) and a counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-010 Channel FSM states SHALL be STABLE (sync2 == level, counter held at 0) and CANDIDATE (sync2 != level, counter incrementing).
REQ-011 STABLE->CANDIDATE SHALL occur on the first cycle sync2 != level; counter becomes 1.
REQ-012 CANDIDATE->STABLE without a level change SHALL occur on any cycle sync2 == level (bounce); counter clears to 0 on that edge.
REQ-013 When the counter equals DEBOUNCE_CYCLES and sync2 still != level, level SHALL toggle and the counter clear on that edge; the counter never exceeds DEBOUNCE_CYCLES and never wraps.
REQ-014 btn_pulse[i] SHALL be 1 for exactly the one cycle after level[i] goes 0->1, otherwise 0; no pulse on 1->0.
REQ-015 Latency: with btn_raw[i] rising and held stable, btn_level[i] and btn_pulse[i] SHALL go high on the (DEBOUNCE_CYCLES+2)th rising edge after the first sampling edge.
REQ-016 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses (no priority arbitration in this block).
REQ-017 A held button SHALL produce exactly one pulse, regardless of hold duration.
REQ-018 any_pulse SHALL be registered in the same cycle as the btn_pulse bits it reflects (computed from next-state pulses), zero added latency.

Reset
REQ-019 While clr is high: sync1, sync2, counters, btn_level, btn_pulse, any_pulse SHALL all be 0 on the next edge.
REQ-020 clr asserted mid-debounce SHALL discard the partial count; no pulse for that press unless it re-qualifies after release of clr.
REQ-021 A button held high through clr deassertion SHALL qualify as a new press and pulse once after DEBOUNCE_CYCLES+2 cycles.
REQ-022 clr SHALL take priority over all other updates in the same cycle.

Structure
REQ-023 Package btn_pkg SHALL hold CLK_HZ (125000000), DEBOUNCE_MS (10), derived DEBOUNCE_CYCLES default and the counter-width function.
REQ-024 One sub-module btn_debounce_ch (synchronizer, counter, level, pulse for one bit) SHALL be instantiated four times; btn_conditioner adds only any_pulse and wiring.
REQ-025 No latches, no gated clocks, no combinational path from btn_raw to any output.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: btn_raw[2] 0->1, held 20 cycles -> btn_level[2] high and btn_pulse[2]/any_pulse high for one cycle on edge 6; no further pulses.
REQ-027 Bounce: btn_raw[3] toggles 1,0,1,0 each cycle then holds 1 -> single pulse exactly 6 edges after the final 0->1; no earlier pulse.
REQ-028 Glitch: btn_raw[1] high for 3 cycles then low -> btn_level[1] and btn_pulse[1] stay 0 throughout.
REQ-029 Simultaneous: btn_raw[0] and btn_raw[3] rise on same edge -> btn_pulse = 4'b1001 for one cycle on edge 6, any_pulse = 1 that cycle.
REQ-030 Reset mid-count: press btn_raw[2], assert clr on edge 4 for 2 cycles while held -> no pulse before clr; one pulse 6 edges after clr deasserts; release -> level falls after 6 edges, no pulse.
